// File: rtl/arbitrated_multiplex_pkg.sv
// rtl/arbitrated_multiplex_pkg.sv - shared constants and helpers for the arbitrated multiplexer (optional feature macro: MUX_PACKET_LOCK_EN)
package multiplex_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Number of channels addressed by an index of the given width
    function automatic int channels(input int address_size);
        return 1 << address_size;
    endfunction

    // LSB position of channel k inside the packed data bus
    function automatic int slice_lsb(input int k, input int width);
        return k * width;
    endfunction

endpackage

// File: rtl/arbitrated_multiplex_if.sv
// rtl/arbitrated_multiplex_if.sv - producer/consumer bus of the arbitrated multiplexer (DLast/QLast present under MUX_PACKET_LOCK_EN)
interface arbitrated_multiplex_if
    import multiplex_pkg::*;
#(
    parameter int Width       = 8,
    parameter int AddressSize = 2
);
    localparam int Channels = channels(AddressSize);

    logic [Width*Channels-1:0] D;
    logic [Channels-1:0]       DValid;
    logic [Channels-1:0]       DReady;
    logic                      Mode;
    logic [AddressSize-1:0]    Sel;
    logic [Width-1:0]          Q;
    logic                      QValid;
    logic                      QReady;
    logic [AddressSize-1:0]    S;
`ifdef MUX_PACKET_LOCK_EN
    logic [Channels-1:0]       DLast;
    logic                      QLast;
`endif

    // Multiplexer side
    modport slave (
        input  D, DValid, Mode, Sel, QReady,
        output DReady, Q, QValid, S
`ifdef MUX_PACKET_LOCK_EN
        , input DLast, output QLast
`endif
    );

    // Producer/consumer side
    modport master (
        output D, DValid, Mode, Sel, QReady,
        input  DReady, Q, QValid, S
`ifdef MUX_PACKET_LOCK_EN
        , output DLast, input QLast
`endif
    );

endinterface

// File: rtl/arbitrated_multiplex_arbiter.sv
// rtl/arbitrated_multiplex_arbiter.sv - combinational round-robin arbiter starting after the last winner
module round_robin_arbiter
    import multiplex_pkg::*;
#(
    parameter int AddressSize = 2
) (
    input  logic [channels(AddressSize)-1:0] Request,
    input  logic [AddressSize-1:0]           Last,
    output logic [channels(AddressSize)-1:0] Grant,
    output logic [AddressSize-1:0]           GrantIndex,
    output logic                             GrantValid
);

    localparam int Channels = channels(AddressSize);

    logic [AddressSize-1:0] w_idx;

    // Scan Last+1, Last+2, ... with natural index wrap; first requester wins
    always_comb begin
        Grant      = '0;
        GrantIndex = '0;
        GrantValid = 1'b0;
        w_idx      = '0;
        for (int i = 1; i <= Channels; i++) begin
            w_idx = Last + AddressSize'(i);
            if (!GrantValid && Request[w_idx]) begin
                GrantValid   = 1'b1;
                GrantIndex   = w_idx;
                Grant[w_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multiplex.sv
// rtl/multiplex.sv - combinational N:1 data selector
module Multiplex
    import multiplex_pkg::*;
#(
    parameter int Width       = 8,
    parameter int AddressSize = 2
) (
    input  logic [Width*channels(AddressSize)-1:0] D,
    input  logic [AddressSize-1:0]                 Sel,
    output logic [Width-1:0]                       Q
);

    assign Q = D[slice_lsb(int'(Sel), Width) +: Width];

endmodule

// File: rtl/arbitrated_multiplex.sv
// rtl/arbitrated_multiplex.sv - registered handshaked N:1 stream mux, fixed or round-robin (MUX_PACKET_LOCK_EN adds packet locking)
module arbitrated_multiplex
    import multiplex_pkg::*;
#(
    parameter int Width       = 8,
    parameter int AddressSize = 2
) (
    input  logic                   Clock,
    input  logic                   ResetN,
    arbitrated_multiplex_if.slave  bus
);

    localparam int Channels = channels(AddressSize);

    logic [Width-1:0]       r_q;
    logic [AddressSize-1:0] r_s;
    logic [AddressSize-1:0] r_last;
    logic                   r_qvalid;
`ifdef MUX_PACKET_LOCK_EN
    logic                   r_qlast;
    logic                   r_locked;
    logic [AddressSize-1:0] r_lock_idx;
`endif

    logic [Channels-1:0]    w_rr_grant;
    logic [AddressSize-1:0] w_rr_idx;
    logic                   w_rr_valid;
    logic [Channels-1:0]    w_grant_onehot;
    logic [AddressSize-1:0] w_grant_idx;
    logic                   w_grant_valid;
    logic                   w_free;
    logic                   w_xfer;
    logic [Width-1:0]       w_mux_q;

    round_robin_arbiter #(.AddressSize(AddressSize)) u_arbiter (
        .Request    (bus.DValid),
        .Last       (r_last),
        .Grant      (w_rr_grant),
        .GrantIndex (w_rr_idx),
        .GrantValid (w_rr_valid)
    );

    // Pick the granted channel: fixed Sel, round-robin winner, or the locked packet owner
    always_comb begin
        w_grant_idx            = bus.Sel;
        w_grant_valid          = bus.DValid[bus.Sel];
        w_grant_onehot         = '0;
        w_grant_onehot[bus.Sel] = 1'b1;
        if (bus.Mode == MODE_RR) begin
            w_grant_idx    = w_rr_idx;
            w_grant_valid  = w_rr_valid;
            w_grant_onehot = w_rr_grant;
        end
`ifdef MUX_PACKET_LOCK_EN
        if (r_locked) begin
            w_grant_idx               = r_lock_idx;
            w_grant_valid             = bus.DValid[r_lock_idx];
            w_grant_onehot            = '0;
            w_grant_onehot[r_lock_idx] = 1'b1;
        end
`endif
    end

    // Output register accepts a beat when empty or being popped this cycle
    assign w_free     = !r_qvalid || bus.QReady;
    assign w_xfer     = ResetN && w_free && w_grant_valid;
    assign bus.DReady = w_xfer ? w_grant_onehot : '0;

    Multiplex #(.Width(Width), .AddressSize(AddressSize)) u_mux (
        .D   (bus.D),
        .Sel (w_grant_idx),
        .Q   (w_mux_q)
    );

    // Output stage, round-robin pointer and packet lock
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            r_q      <= '0;
            r_s      <= '0;
            r_qvalid <= 1'b0;
            r_last   <= '1;
`ifdef MUX_PACKET_LOCK_EN
            r_qlast    <= 1'b0;
            r_locked   <= 1'b0;
            r_lock_idx <= '0;
`endif
        end else if (w_xfer) begin
            r_q      <= w_mux_q;
            r_s      <= w_grant_idx;
            r_qvalid <= 1'b1;
            if (bus.Mode == MODE_RR) begin
                r_last <= w_grant_idx;
            end
`ifdef MUX_PACKET_LOCK_EN
            r_qlast    <= bus.DLast[w_grant_idx];
            r_locked   <= !bus.DLast[w_grant_idx];
            r_lock_idx <= w_grant_idx;
`endif
        end else if (bus.QReady) begin
            r_qvalid <= 1'b0;
        end
    end

    assign bus.Q      = r_q;
    assign bus.S      = r_s;
    assign bus.QValid = r_qvalid;
`ifdef MUX_PACKET_LOCK_EN
    assign bus.QLast  = r_qlast;
`endif

endmodule

// File: tb/tb_arbitrated_multiplex.sv
// tb/tb_arbitrated_multiplex.sv - directed self-checking bench for arbitrated_multiplex (exercises MUX_PACKET_LOCK_EN when defined)
module tb_arbitrated_multiplex;

    logic Clock;
    logic ResetN;
    int   n_checks;
    int   n_pass;

    arbitrated_multiplex_if #(.Width(8), .AddressSize(2)) bus ();

    arbitrated_multiplex #(.Width(8), .AddressSize(2)) dut (
        .Clock  (Clock),
        .ResetN (ResetN),
        .bus    (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    logic [7:0] rr_q [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    logic [1:0] rr_s [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        ResetN     = 1'b0;
        bus.D      = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.DValid = 4'hF;
        bus.Mode   = 1'b1;
        bus.Sel    = 2'd0;
        bus.QReady = 1'b0;
`ifdef MUX_PACKET_LOCK_EN
        bus.DLast  = 4'hF;
`endif

        // Reset held for two edges
        tick();
        tick();
        check("rst_qvalid", 32'(bus.QValid), 32'd0);
        check("rst_q",      32'(bus.Q),      32'h0);
        check("rst_s",      32'(bus.S),      32'd0);
        check("rst_dready", 32'(bus.DReady), 32'h0);

        // Release: channel 0 has first priority, then fair rotation
        ResetN     = 1'b1;
        bus.QReady = 1'b1;
        #1;
        check("first_dready", 32'(bus.DReady), 32'h1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("rr_q%0d", i),  32'(bus.Q),      32'(rr_q[i]));
            check($sformatf("rr_s%0d", i),  32'(bus.S),      32'(rr_s[i]));
            check($sformatf("rr_v%0d", i),  32'(bus.QValid), 32'd1);
        end

        // Fixed mode, channel 2, then backpressure
        bus.Mode       = 1'b0;
        bus.Sel        = 2'd2;
        bus.D[23:16]   = 8'hA5;
        tick();
        check("fix_q", 32'(bus.Q), 32'hA5);
        check("fix_s", 32'(bus.S), 32'd2);
        bus.QReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bp_dready%0d", i), 32'(bus.DReady), 32'h0);
            tick();
            check($sformatf("bp_q%0d", i), 32'(bus.Q),      32'hA5);
            check($sformatf("bp_s%0d", i), 32'(bus.S),      32'd2);
            check($sformatf("bp_v%0d", i), 32'(bus.QValid), 32'd1);
        end
        bus.D[23:16] = 8'h5A;
        bus.QReady   = 1'b1;
        #1;
        check("bp_release_dready", 32'(bus.DReady), 32'h4);
        tick();
        check("bp_release_q", 32'(bus.Q), 32'h5A);
        check("bp_release_s", 32'(bus.S), 32'd2);

        // Sparse round-robin requests; pointer still 0 after fixed-mode beats
        bus.D      = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.Mode   = 1'b1;
        bus.DValid = 4'b1010;
        tick();
        check("sp_s0", 32'(bus.S), 32'd1);
        check("sp_q0", 32'(bus.Q), 32'h22);
        tick();
        check("sp_s1", 32'(bus.S), 32'd3);
        check("sp_q1", 32'(bus.Q), 32'h44);
        tick();
        check("sp_s2", 32'(bus.S), 32'd1);
        tick();
        check("sp_s3", 32'(bus.S), 32'd3);
        bus.DValid = 4'h0;
        tick();
        check("drain_v", 32'(bus.QValid), 32'd0);
        check("drain_q", 32'(bus.Q),      32'h44);
        check("drain_s", 32'(bus.S),      32'd3);

        // Reset mid-stream with data held
        bus.DValid = 4'hF;
        tick();
        check("pre_rst_s", 32'(bus.S),      32'd0);
        check("pre_rst_v", 32'(bus.QValid), 32'd1);
        bus.QReady = 1'b0;
        ResetN     = 1'b0;
        #1;
        check("mid_rst_dready", 32'(bus.DReady), 32'h0);
        tick();
        check("mid_rst_v", 32'(bus.QValid), 32'd0);
        check("mid_rst_q", 32'(bus.Q),      32'h0);
        ResetN     = 1'b1;
        bus.QReady = 1'b1;
        #1;
        check("post_rst_dready", 32'(bus.DReady), 32'h1);
        tick();
        check("post_rst_s", 32'(bus.S), 32'd0);
        check("post_rst_q", 32'(bus.Q), 32'h11);

`ifdef MUX_PACKET_LOCK_EN
        // Channel 1 sends a 3-beat packet while channel 2 competes
        bus.DValid = 4'b0110;
        bus.DLast  = 4'b0100;
        tick();
        check("lk_s0", 32'(bus.S),     32'd1);
        check("lk_l0", 32'(bus.QLast), 32'd0);
        tick();
        check("lk_s1", 32'(bus.S),     32'd1);
        check("lk_l1", 32'(bus.QLast), 32'd0);
        bus.DLast = 4'b0110;
        tick();
        check("lk_s2", 32'(bus.S),     32'd1);
        check("lk_l2", 32'(bus.QLast), 32'd1);
        tick();
        check("lk_s3", 32'(bus.S),     32'd2);
        check("lk_q3", 32'(bus.Q),     32'h33);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/arbitrated_multiplex.md
Name: arbitrated_multiplex

Overview:
- Registered, handshaked N:1 stream multiplexer.
- Successor to the combinational Multiplex: same Width/AddressSize generalisation, plus per-channel valid/ready, one output register stage, and a runtime choice between fixed-select and round-robin arbitration.
- Sits between multiple producer channels and a single consumer, e.g. funnelling individual/fitness streams into one evaluator.

Parameters:
- Width, 8, data bits per channel.
- AddressSize, 2, channel index bits; Channels = 2**AddressSize.

Ports:
- Clock  in  1  rising-edge clock.
- ResetN  in  1  synchronous, active-low reset.
- D  in  Width*Channels  packed channel data; channel k at bits [k*Width +: Width].
- DValid  in  Channels  per-channel valid.
- DReady  out  Channels  per-channel ready; at most one bit high.
- Mode  in  1  0 = fixed (use Sel), 1 = round-robin.
- Sel  in  AddressSize  channel selected in fixed mode.
- Q  out  Width  registered output data.
- QValid  out  1  output valid.
- QReady  in  1  consumer ready.
- S  out  AddressSize  index of the channel that produced Q.

Behaviour:
- Reset (ResetN=0 at a rising edge): QValid=0, Q=0, S=0, round-robin pointer Last=Channels-1, so channel 0 has first priority. DReady is combinationally 0 while ResetN=0.
- Output register is free when QValid=0, or when QValid=1 and QReady=1 (a pop in the same cycle).
- Grant, combinational:
  - Fixed mode: channel Sel is granted if DValid[Sel]=1.
  - Round-robin mode: the first requesting channel scanning Last+1, Last+2 … wrapping modulo Channels.
  - No requester means no grant.
- DReady[g] = grant g AND output register free. All other DReady bits are 0.
- Transfer happens when DValid[g]=1 and DReady[g]=1. At the next edge: Q = D[g], S = g, QValid = 1. In round-robin mode only, Last = g.
- Pop without a transfer: QValid=1 and QReady=1 with no transfer gives QValid=0. Q and S hold their values.
- Pop and transfer in the same cycle: new data loaded, QValid stays 1. Full throughput of one beat per cycle.
- Backpressure: QValid=1, QReady=0 gives DReady all 0; Q and S are stable.
- Latency is 1 cycle from an accepted input to QValid.
- Mode or Sel change mid-stream: takes effect at the next grant evaluation. A held output is unaffected. Last is not modified in fixed mode.
- Reset asserted mid-operation: an in-flight Q is discarded (QValid=0 next edge) and the pointer returns to Channels-1.
- Single requester in round-robin mode: granted every free cycle.
- DValid on a non-granted channel has no effect and is not dropped; the producer holds it.

Optional Feature:
- Macro: MUX_PACKET_LOCK_EN.
- Defined: adds ports DLast (in, Channels) and QLast (out, 1); QLast is registered with Q and reset to 0.
  - A transfer with DLast[g]=0 locks the grant to g. Arbitration, and Sel/Mode changes, are ignored until a transfer with DLast[g]=1 releases the lock.
  - Reset clears the lock.
- Undefined: no DLast/QLast ports; arbitration is per beat.

Decomposition:
- Package multiplex_pkg:
  - Channels derivation function/constant.
  - Mode constants MODE_FIXED=1'b0, MODE_RR=1'b1.
  - Channel-slice helper.
- Sub-module round_robin_arbiter: inputs Request[Channels] and Last; outputs one-hot Grant and GrantIndex, combinational.
- Data path select reuses the existing Multiplex (Width, AddressSize) driven by the grant index.

Test Plan (Width=8, AddressSize=2):
- Reset: ResetN=0 for 2 cycles with DValid=4'hF → QValid=0, Q=0, S=0, DReady=0. After release, first grant is channel 0.
- Round-robin fairness: Mode=1, DValid=4'hF held, QReady=1, D = {8'h44, 8'h33, 8'h22, 8'h11} → Q sequence 11,22,33,44,11 with S = 0,1,2,3,0, one per cycle.
- Fixed mode with backpressure: Mode=0, Sel=2, D2=8'hA5, QReady=0 for 3 cycles → Q=A5, S=2, QValid=1 stable, DReady=0. Then QReady=1 → next beat accepted the same cycle.
- Sparse requests: Mode=1, DValid=4'b1010 → grants alternate S=1,3,1,3. Then DValid=0 → QValid drops after the pending pop.
- Reset mid-stream: QValid=1, QReady=0, pulse ResetN=0 → QValid=0 next edge. Next round-robin grant with DValid=4'hF is channel 0.
- MUX_PACKET_LOCK_EN: Mode=1, channel 1 sends 3 beats with DLast=0,0,1 while channel 2 is valid → S=1,1,1 then S=2.
